// File: rtl/count_timer_core.sv
// Count source for the seven-segment display: signed/unsigned event counter and MM:SS stopwatch.
// Optional lap hold enabled by defining COUNT_TIMER_LAP_EN (adds the lap input).
module count_timer_core #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mod_sel,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        evt,
  input  logic        up_dn,
`ifdef COUNT_TIMER_LAP_EN
  input  logic        lap,
`endif
  output logic [13:0] cnt1,
  output logic [6:0]  cnt2,
  output logic        sign,
  output logic        valid,
  output logic        dp_en,
  output logic [1:0]  dp_sel,
  output logic        running
);

  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [13:0]     MinMax = 14'(MAX_MIN);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StOvf} state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q;
  logic [PreW-1:0] pre_q, pre_d;
  logic [13:0]     mag_q, mag_d;
  logic [5:0]      sec_q, sec_d;
  logic            neg_q, neg_d;
  logic            hold_q, hold_d;
  logic            clr_eff, ovf, upd;

  logic [13:0] cnt1_q, cnt1_d;
  logic [6:0]  cnt2_q, cnt2_d;
  logic        sign_q, sign_d;
  logic        valid_q, valid_d;
  logic        dp_en_q, dp_en_d;
  logic [1:0]  dp_sel_q, dp_sel_d;
  logic        running_q, running_d;

  always_comb begin
    clr_eff = clear | (mod_sel != mode_q);
    state_d = state_q;
    pre_d   = pre_q;
    mag_d   = mag_q;
    sec_d   = sec_q;
    neg_d   = neg_q;
    ovf     = 1'b0;

    if (clr_eff) begin
      state_d = StIdle;
      pre_d   = '0;
      mag_d   = '0;
      sec_d   = '0;
      neg_d   = 1'b0;
    end else if (mod_sel == 2'd3) begin
      state_d = StIdle;
    end else begin
      if (state_q == StRun) begin
        case (mod_sel)
          2'd0: begin
            if (evt) begin
              // Sign-magnitude: the magnitude grows when the step direction matches the sign.
              if (up_dn ^ neg_q) begin
                if (mag_q == 14'd999) ovf = 1'b1;
                else mag_d = mag_q + 14'd1;
              end else if (mag_q == 14'd0) begin
                neg_d = 1'b1;
                mag_d = 14'd1;
              end else begin
                mag_d = mag_q - 14'd1;
                if (mag_q == 14'd1) neg_d = 1'b0;
              end
            end
          end
          2'd1: begin
            if (pre_q == PreMax) begin
              pre_d = '0;
              if (sec_q == 6'd59) begin
                if (mag_q == MinMax) begin
                  ovf = 1'b1;
                end else begin
                  sec_d = '0;
                  mag_d = mag_q + 14'd1;
                end
              end else begin
                sec_d = sec_q + 6'd1;
              end
            end else begin
              pre_d = pre_q + PreW'(1);
            end
          end
          2'd2: begin
            if (evt) begin
              if (up_dn) begin
                if (mag_q == 14'd9999) ovf = 1'b1;
                else mag_d = mag_q + 14'd1;
              end else if (mag_q != 14'd0) begin
                mag_d = mag_q - 14'd1;
              end
            end
          end
          default: ;
        endcase
      end

      if (ovf) begin
        state_d = StOvf;
      end else if (start_stop) begin
        case (state_q)
          StIdle:  state_d = StRun;
          StRun:   state_d = StPause;
          StPause: state_d = StRun;
          default: ;
        endcase
      end
    end

`ifdef COUNT_TIMER_LAP_EN
    hold_d = hold_q;
    if (clr_eff) hold_d = 1'b0;
    else if (lap && (state_q == StRun)) hold_d = ~hold_q;
`else
    hold_d = 1'b0;
`endif
    // The count outputs refresh unless a lap hold was already in force before this edge.
    upd = ~hold_q | clr_eff;

    cnt1_d    = (mod_sel == 2'd3) ? 14'd0 : mag_d;
    cnt2_d    = (mod_sel == 2'd1) ? {1'b0, sec_d} : 7'd0;
    sign_d    = (mod_sel == 2'd0) ? neg_d : 1'b0;
    valid_d   = (state_d != StOvf);
    running_d = (state_d == StRun);
    dp_en_d   = (mod_sel == 2'd1);
    dp_sel_d  = (mod_sel == 2'd1) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= mod_sel;
      pre_q     <= '0;
      mag_q     <= '0;
      sec_q     <= '0;
      neg_q     <= 1'b0;
      hold_q    <= 1'b0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      sign_q    <= 1'b0;
      valid_q   <= 1'b1;
      dp_en_q   <= 1'b0;
      dp_sel_q  <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mod_sel;
      pre_q     <= pre_d;
      mag_q     <= mag_d;
      sec_q     <= sec_d;
      neg_q     <= neg_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      dp_en_q   <= dp_en_d;
      dp_sel_q  <= dp_sel_d;
      running_q <= running_d;
      if (upd) begin
        cnt1_q <= cnt1_d;
        cnt2_q <= cnt2_d;
        sign_q <= sign_d;
      end
    end
  end

  assign cnt1    = cnt1_q;
  assign cnt2    = cnt2_q;
  assign sign    = sign_q;
  assign valid   = valid_q;
  assign dp_en   = dp_en_q;
  assign dp_sel  = dp_sel_q;
  assign running = running_q;

endmodule

// File: tb/tb_count_timer_core.sv
// Self-checking bench for count_timer_core: directed scenarios plus randomized traffic
// checked against a value-level reference model. Lap checks run when COUNT_TIMER_LAP_EN is defined.
module tb_count_timer_core;

  localparam int unsigned TD = 4;
  localparam int unsigned MM = 2;
`ifdef COUNT_TIMER_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  localparam int SIdle = 0, SRun = 1, SPause = 2, SOvf = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mod_sel;
  logic        start_stop, clear, evt, up_dn;
`ifdef COUNT_TIMER_LAP_EN
  logic        lap;
`endif
  logic [13:0] cnt1;
  logic [6:0]  cnt2;
  logic        sign, valid, dp_en, running;
  logic [1:0]  dp_sel;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the count as a plain signed integer / total seconds.
  int m_mode, m_st, m_v, m_secs, m_pre;
  bit m_hold;
  int e_c1, e_c2;
  bit e_sg;

  count_timer_core #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mod_sel    (mod_sel),
    .start_stop (start_stop),
    .clear      (clear),
    .evt        (evt),
    .up_dn      (up_dn),
`ifdef COUNT_TIMER_LAP_EN
    .lap        (lap),
`endif
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .sign       (sign),
    .valid      (valid),
    .dp_en      (dp_en),
    .dp_sel     (dp_sel),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic model_reset(input int ms);
    m_mode = ms; m_st = SIdle; m_v = 0; m_secs = 0; m_pre = 0; m_hold = 1'b0;
    e_c1 = 0; e_c2 = 0; e_sg = 1'b0;
  endtask

  task automatic model_step(input int ms, input bit ss, input bit clr, input bit e,
                            input bit ud, input bit lp);
    bit ce, ovf, hold_old;
    int st_old;
    ce = clr || (ms != m_mode);
    ovf = 1'b0;
    hold_old = m_hold;
    st_old = m_st;
    m_mode = ms;
    if (ce) begin
      m_v = 0; m_secs = 0; m_pre = 0; m_st = SIdle; m_hold = 1'b0;
    end else if (ms == 3) begin
      m_st = SIdle;
    end else begin
      if (st_old == SRun) begin
        if (ms == 0 && e) begin
          if (ud) begin if (m_v == 999) ovf = 1'b1; else m_v++; end
          else begin if (m_v == -999) ovf = 1'b1; else m_v--; end
        end else if (ms == 2 && e) begin
          if (ud) begin if (m_v == 9999) ovf = 1'b1; else m_v++; end
          else if (m_v > 0) m_v--;
        end else if (ms == 1) begin
          if (m_pre == TD - 1) begin
            m_pre = 0;
            if (m_secs == MM * 60 + 59) ovf = 1'b1; else m_secs++;
          end else m_pre++;
        end
      end
      if (ovf) m_st = SOvf;
      else if (ss && m_st != SOvf) m_st = (m_st == SRun) ? SPause : SRun;
      if (LapEn && lp && st_old == SRun) m_hold = !m_hold;
    end
    if (!hold_old || ce) begin
      e_c1 = (ms == 1) ? m_secs / 60 : ((m_v < 0) ? -m_v : m_v);
      e_c2 = (ms == 1) ? m_secs % 60 : 0;
      e_sg = (ms == 0) && (m_v < 0);
    end
  endtask

  task automatic step(input logic [1:0] ms, input logic ss, input logic clr, input logic e,
                      input logic ud, input logic lp);
    mod_sel = ms; start_stop = ss; clear = clr; evt = e; up_dn = ud;
`ifdef COUNT_TIMER_LAP_EN
    lap = lp;
`endif
    @(posedge clk);
    if (!rst_n) model_reset(int'(ms));
    else model_step(int'(ms), ss, clr, e, ud, lp);
    #1;
    start_stop = 1'b0; clear = 1'b0; evt = 1'b0;
`ifdef COUNT_TIMER_LAP_EN
    lap = 1'b0;
`endif
  endtask

  task automatic idle(input logic [1:0] ms, input int n);
    for (int i = 0; i < n; i++) step(ms, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic events(input logic [1:0] ms, input logic ud, input int n);
    for (int i = 0; i < n; i++) step(ms, 1'b0, 1'b0, 1'b1, ud, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (cnt1 !== 14'd0) begin n_err++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
    n_cmp++; if (cnt2 !== 7'd0) begin n_err++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
    n_cmp++; if (sign !== 1'b0) begin n_err++; $display("FAIL reset_sign: got %b want 0", sign); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL reset_valid: got %b want 1", valid); end
    n_cmp++; if (dp_en !== 1'b0) begin n_err++; $display("FAIL reset_dp_en: got %b want 0", dp_en); end
    n_cmp++; if (dp_sel !== 2'd0) begin n_err++; $display("FAIL reset_dp_sel: got %0d want 0", dp_sel); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    rst_n = 1'b1;
  endtask

  task automatic test_stopwatch_minute;
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 4 * 60);
    n_cmp++; if (cnt1 !== 14'd1) begin n_err++; $display("FAIL sw_min_cnt1: got %0d want 1", cnt1); end
    n_cmp++; if (cnt2 !== 7'd0) begin n_err++; $display("FAIL sw_min_cnt2: got %0d want 0", cnt2); end
    n_cmp++; if (dp_en !== 1'b1) begin n_err++; $display("FAIL sw_min_dp_en: got %b want 1", dp_en); end
    n_cmp++; if (dp_sel !== 2'd1) begin n_err++; $display("FAIL sw_min_dp_sel: got %0d want 1", dp_sel); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL sw_min_running: got %b want 1", running); end
  endtask

  task automatic test_signed;
    idle(2'd0, 1);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    events(2'd0, 1'b0, 3);
    n_cmp++; if ({sign, cnt1} !== {1'b1, 14'd3}) begin
      n_err++; $display("FAIL signed_down3: got sign=%b cnt1=%0d want sign=1 cnt1=3", sign, cnt1); end
    events(2'd0, 1'b1, 4);
    n_cmp++; if ({sign, cnt1} !== {1'b0, 14'd1}) begin
      n_err++; $display("FAIL signed_up4: got sign=%b cnt1=%0d want sign=0 cnt1=1", sign, cnt1); end
    events(2'd0, 1'b1, 998);
    n_cmp++; if ({valid, cnt1} !== {1'b1, 14'd999}) begin
      n_err++; $display("FAIL signed_999: got valid=%b cnt1=%0d want valid=1 cnt1=999", valid, cnt1); end
    events(2'd0, 1'b1, 1);
    n_cmp++; if ({valid, running, sign, cnt1} !== {1'b0, 1'b0, 1'b0, 14'd999}) begin
      n_err++; $display("FAIL signed_ovf_pos: got valid=%b run=%b sign=%b cnt1=%0d want 0 0 0 999",
                        valid, running, sign, cnt1); end
    step(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({valid, running, cnt1} !== {1'b0, 1'b0, 14'd999}) begin
      n_err++; $display("FAIL ovf_ignores_start: got valid=%b run=%b cnt1=%0d want 0 0 999",
                        valid, running, cnt1); end
    step(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    events(2'd0, 1'b0, 999);
    n_cmp++; if ({valid, sign, cnt1} !== {1'b1, 1'b1, 14'd999}) begin
      n_err++; $display("FAIL signed_m999: got valid=%b sign=%b cnt1=%0d want 1 1 999", valid, sign, cnt1); end
    events(2'd0, 1'b0, 1);
    n_cmp++; if ({valid, sign, cnt1} !== {1'b0, 1'b1, 14'd999}) begin
      n_err++; $display("FAIL signed_ovf_neg: got valid=%b sign=%b cnt1=%0d want 0 1 999", valid, sign, cnt1); end
  endtask

  task automatic test_unsigned;
    idle(2'd2, 1);
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    events(2'd2, 1'b0, 2);
    n_cmp++; if ({valid, sign, cnt1} !== {1'b1, 1'b0, 14'd0}) begin
      n_err++; $display("FAIL unsigned_sat0: got valid=%b sign=%b cnt1=%0d want 1 0 0", valid, sign, cnt1); end
    events(2'd2, 1'b1, 9999);
    n_cmp++; if ({valid, cnt1} !== {1'b1, 14'd9999}) begin
      n_err++; $display("FAIL unsigned_9999: got valid=%b cnt1=%0d want 1 9999", valid, cnt1); end
    events(2'd2, 1'b1, 1);
    n_cmp++; if ({valid, running, cnt1} !== {1'b0, 1'b0, 14'd9999}) begin
      n_err++; $display("FAIL unsigned_ovf: got valid=%b run=%b cnt1=%0d want 0 0 9999", valid, running, cnt1); end
    step(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({valid, running, cnt1} !== {1'b1, 1'b0, 14'd0}) begin
      n_err++; $display("FAIL unsigned_clear: got valid=%b run=%b cnt1=%0d want 1 0 0", valid, running, cnt1); end
  endtask

  task automatic test_pause_resume;
    idle(2'd1, 1);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 1);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 20);
    n_cmp++; if ({running, valid, cnt2} !== {1'b0, 1'b1, 7'd0}) begin
      n_err++; $display("FAIL paused: got run=%b valid=%b cnt2=%0d want 0 1 0", running, valid, cnt2); end
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({running, cnt2} !== {1'b1, 7'd0}) begin
      n_err++; $display("FAIL resume_edge: got run=%b cnt2=%0d want 1 0", running, cnt2); end
    idle(2'd1, 1);
    n_cmp++; if (cnt2 !== 7'd0) begin n_err++; $display("FAIL resume_plus1: got %0d want 0", cnt2); end
    idle(2'd1, 1);
    n_cmp++; if (cnt2 !== 7'd1) begin n_err++; $display("FAIL resume_plus2: got %0d want 1", cnt2); end
  endtask

  task automatic test_clear_and_mode;
    idle(2'd1, 10);
    step(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({running, cnt1, cnt2} !== {1'b0, 14'd0, 7'd0}) begin
      n_err++; $display("FAIL clear_wins: got run=%b cnt1=%0d cnt2=%0d want 0 0 0", running, cnt1, cnt2); end
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 10);
    n_cmp++; if ({running, cnt2} !== {1'b1, 7'd2}) begin
      n_err++; $display("FAIL rerun: got run=%b cnt2=%0d want 1 2", running, cnt2); end
    idle(2'd2, 1);
    n_cmp++; if ({running, dp_en, cnt1, cnt2} !== {1'b0, 1'b0, 14'd0, 7'd0}) begin
      n_err++; $display("FAIL mode_change: got run=%b dp_en=%b cnt1=%0d cnt2=%0d want 0 0 0 0",
                        running, dp_en, cnt1, cnt2); end
  endtask

  task automatic test_stopwatch_ovf;
    idle(2'd1, 1);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 4 * (MM * 60 + 59));
    n_cmp++; if ({valid, cnt1, cnt2} !== {1'b1, 14'(MM), 7'd59}) begin
      n_err++; $display("FAIL sw_max: got valid=%b %0d:%0d want 1 %0d:59", valid, cnt1, cnt2, MM); end
    idle(2'd1, 4);
    n_cmp++; if ({valid, running, cnt1, cnt2} !== {1'b0, 1'b0, 14'(MM), 7'd59}) begin
      n_err++; $display("FAIL sw_ovf: got valid=%b run=%b %0d:%0d want 0 0 %0d:59",
                        valid, running, cnt1, cnt2, MM); end
    idle(2'd1, 8);
    n_cmp++; if ({valid, cnt1, cnt2} !== {1'b0, 14'(MM), 7'd59}) begin
      n_err++; $display("FAIL sw_ovf_hold: got valid=%b %0d:%0d want 0 %0d:59", valid, cnt1, cnt2, MM); end
    idle(2'd3, 1);
    step(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({valid, running, dp_en, cnt1, cnt2} !== {1'b1, 1'b0, 1'b0, 14'd0, 7'd0}) begin
      n_err++; $display("FAIL mode3: got valid=%b run=%b dp_en=%b cnt1=%0d cnt2=%0d want 1 0 0 0 0",
                        valid, running, dp_en, cnt1, cnt2); end
  endtask

`ifdef COUNT_TIMER_LAP_EN
  task automatic test_lap;
    step(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2'd1, 4 * 5);
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2'd1, 12);
    n_cmp++; if ({cnt1, cnt2} !== {14'd0, 7'd5}) begin
      n_err++; $display("FAIL lap_hold: got %0d:%0d want 0:5", cnt1, cnt2); end
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2'd1, 1);
    n_cmp++; if ({cnt1, cnt2} !== {14'd0, 7'd8}) begin
      n_err++; $display("FAIL lap_release: got %0d:%0d want 0:8", cnt1, cnt2); end
  endtask
`endif

  task automatic test_random;
    logic [1:0]  ms;
    logic [26:0] act, exp;
    int shown = 0;
    ms = mod_sel;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) ms = 2'($urandom_range(3));
      step(ms, $urandom_range(29) == 0, $urandom_range(299) == 0, $urandom_range(1) == 0,
           $urandom_range(9) < 6, $urandom_range(39) == 0);
      act = {cnt1, cnt2, sign, valid, dp_en, dp_sel, running};
      exp = {14'(e_c1), 7'(e_c2), e_sg, m_st != SOvf, m_mode == 1,
             (m_mode == 1) ? 2'd1 : 2'd0, m_st == SRun};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random[%0d]: got cnt1=%0d cnt2=%0d sgn=%b vld=%b dpe=%b dps=%0d run=%b want %0d %0d %b %b %b %0d %b",
                   i, cnt1, cnt2, sign, valid, dp_en, dp_sel, running, exp[26:13], exp[12:6],
                   exp[5], exp[4], exp[3], exp[2:1], exp[0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; mod_sel = 2'd1; start_stop = 1'b0; clear = 1'b0; evt = 1'b0; up_dn = 1'b0;
`ifdef COUNT_TIMER_LAP_EN
    lap = 1'b0;
`endif
    model_reset(1);
    test_reset;
    test_stopwatch_minute;
    test_signed;
    test_unsigned;
    test_pause_resume;
    test_clear_and_mode;
    test_stopwatch_ovf;
`ifdef COUNT_TIMER_LAP_EN
    test_lap;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_timer_core.md
Name: count_timer_core

Overview:
- Count source for the four-digit seven-segment display path. Produces the 14-bit primary count, the 7-bit secondary count, the sign, valid and decimal-point controls that the display formatter consumes.
- Three operating modes, selected by the same mod_sel bus that drives the formatter:
  - mode 0: signed event counter.
  - mode 1: MM:SS stopwatch.
  - mode 2: unsigned event counter.
- A run/pause/overflow state machine gates all counting.

Parameters:
TICK_DIV, 100000000, clk cycles per stopwatch second (mode 1); minimum 2
MAX_MIN, 99, largest minutes value in mode 1

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  synchronous active-low reset
mod_sel  input  2  mode: 0 signed events, 1 MM:SS timer, 2 unsigned events, 3 blank
start_stop  input  1  single-cycle pulse (already debounced): run/pause toggle
clear  input  1  single-cycle pulse: zero counts, return to IDLE
evt  input  1  single-cycle event pulse (modes 0/2)
up_dn  input  1  1 = count up, 0 = count down (modes 0/2 only)
cnt1  output  14  mode 0: magnitude 0..999; mode 1: minutes; mode 2: 0..9999; mode 3: 0
cnt2  output  7  mode 1: seconds 0..59; otherwise 0
sign  output  1  1 = negative (mode 0 only)
valid  output  1  0 while in OVF state
dp_en  output  1  decimal point enable
dp_sel  output  2  decimal point digit position
running  output  1  1 while in RUN state

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE and the prescaler goes to 0.
  - cnt1=0, cnt2=0, sign=0, valid=1, dp_en=0, dp_sel=0, running=0.
  - Reset mid-count discards all state.
- All outputs are registered. A qualifying input pulse is reflected on the outputs at the first clk edge after it is sampled, i.e. 1-cycle latency.
- States: IDLE, RUN, PAUSE, OVF.
  - IDLE: start_stop goes to RUN.
  - RUN: start_stop goes to PAUSE.
  - PAUSE: start_stop goes to RUN.
  - OVF: start_stop is ignored.
  - clear from any state: zero cnt1/cnt2/sign/prescaler and go to IDLE.
  - clear and start_stop in the same cycle: clear wins, result is IDLE.
- Any change of mod_sel (compared against its registered copy) acts as clear on the following edge.
- Counting happens only in RUN. evt and ticks are ignored in IDLE, PAUSE and OVF.
- Mode 0, signed event counter:
  - Value held as sign-magnitude, range -999..+999.
  - evt with up_dn=1 adds 1; evt with up_dn=0 subtracts 1.
  - Crossing zero flips sign properly: -1 +1 gives 0; 0 -1 gives sign=1, mag=1.
  - Zero always has sign=0.
  - Moving beyond ±999 enters OVF and holds the last in-range value.
  - dp_en=0.
- Mode 2, unsigned event counter:
  - Range 0..9999.
  - Up from 9999 enters OVF.
  - Down from 0 stays at 0 (saturates, no OVF).
  - sign=0, dp_en=0.
- Mode 1, stopwatch:
  - The prescaler counts 0..TICK_DIV-1 in RUN and holds its value in PAUSE.
  - When the prescaler reaches TICK_DIV-1, it wraps to 0 and seconds increment on the same edge.
  - Seconds wrap 59 to 0 and carry into minutes.
  - MAX_MIN:59 plus one tick enters OVF with the displayed value held.
  - up_dn and evt are ignored.
  - dp_en=1, dp_sel=1 (point between minutes and seconds). sign=0.
- Mode 3: all counts are 0, valid=1, dp_en=0. The state machine is forced to IDLE.
- OVF: valid=0 and running=0; counts are frozen. Only clear, a mode change or reset leaves OVF.
- evt and a tick in the same cycle are impossible, because the modes are exclusive.

Optional Feature:
- Macro: COUNT_TIMER_LAP_EN.
- When defined:
  - Adds input lap (1-bit pulse).
  - In RUN, lap toggles a hold flag. While the hold flag is set, cnt1/cnt2/sign are frozen at the value captured on the lap edge, while internal counting continues.
  - A second lap releases the hold; outputs show the live value on the next edge.
  - clear, a mode change or reset also release the hold.
- When undefined: no lap port; outputs always track the live count.

Test Plan:
- Reset then mode 1 with TICK_DIV=4: start_stop, then 4*60 cycles -> cnt1=1, cnt2=0, dp_en=1, dp_sel=1, running=1.
- Mode 0, RUN, three evt with up_dn=0 -> sign=1, cnt1=3; then four evt with up_dn=1 -> sign=0, cnt1=1.
- Mode 2, RUN, preload to 9999 via events, one more up evt -> valid=0, cnt1=9999; clear -> valid=1, cnt1=0, IDLE.
- Mode 1, TICK_DIV=4, pause after 2 prescaler counts, hold 20 cycles, resume -> the first second increments exactly 2 cycles after resume.
- clear and start_stop asserted in the same cycle while in RUN -> running=0, counts 0; a mod_sel change mid-RUN -> same result one edge later.
- With COUNT_TIMER_LAP_EN, mode 1: lap at 0:05, run 3 s -> outputs stay 0:05; second lap -> outputs 0:08.
